// File: rtl/arm_pkg.sv
// Shared ARM pipeline definitions: operand-forward mux encodings and the PC register index.
package arm_pkg;

    localparam logic [1:0] FWD_SEL_REG = 2'b00;  // operand from register file
    localparam logic [1:0] FWD_SEL_MEM = 2'b01;  // operand from MEM-stage result
    localparam logic [1:0] FWD_SEL_WB  = 2'b10;  // operand from WB-stage result

    localparam logic [3:0] REG_PC = 4'hF;        // R15: served by the PC path, never forwarded

    localparam int NUM_SRC = 2;                  // ALU operands that can be forwarded

endpackage : arm_pkg

// File: rtl/forwarding_unit_fwd_select.sv
// Forward-source selection for a single EXE operand: compares one source tag
// against the MEM and WB destinations and returns the mux select.
module fwd_select
    import arm_pkg::*;
#(
    parameter int REG_W      = 4,
    parameter bit EXCLUDE_PC = 1'b1
) (
    input  logic [REG_W-1:0] tag,
    input  logic             use_en,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_en,
    input  logic [REG_W-1:0] wb_dest,
    input  logic             wb_en,
    output logic [1:0]       sel
);

    localparam logic [REG_W-1:0] PC_TAG = REG_W'(REG_PC);

    logic tag_is_pc;
    logic hit_mem;
    logic hit_wb;

    assign tag_is_pc = EXCLUDE_PC && (tag == PC_TAG);
    assign hit_mem   = mem_en && (mem_dest == tag);
    assign hit_wb    = wb_en && (wb_dest == tag);

    // MEM holds the youngest result, so it wins over WB when both match
    always_comb begin
        sel = FWD_SEL_REG;
        if (use_en && !tag_is_pc) begin
            if (hit_mem) begin
                sel = FWD_SEL_MEM;
            end else if (hit_wb) begin
                sel = FWD_SEL_WB;
            end
        end
    end

endmodule : fwd_select

// File: rtl/forwarding_unit.sv
// EXE-stage operand forwarding: registers the ID source tags into EXE, drives the
// ALU operand selects from them, and counts forward events for performance debug.
module forwarding_unit
    import arm_pkg::*;
#(
    parameter int REG_W      = 4,
    parameter int CNT_W      = 16,
    parameter bit EXCLUDE_PC = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             forwardingEnabled,
    input  logic             freeze,
    input  logic             flush,
    input  logic             clear_counters,
    input  logic             valid_id,
    input  logic             twoSrc_id,
    input  logic [REG_W-1:0] src1_id,
    input  logic [REG_W-1:0] src2_id,
    input  logic [REG_W-1:0] destination_mem,
    input  logic             writeBackEnabled_mem,
    input  logic [REG_W-1:0] destination_wb,
    input  logic             writeBackEnabled_wb,
    output logic [1:0]       sel_src1,
    output logic [1:0]       sel_src2,
    output logic             valid_exe,
    output logic             twoSrc_exe,
    output logic [REG_W-1:0] src1_exe,
    output logic [REG_W-1:0] src2_exe,
    output logic [CNT_W-1:0] fwd_count_mem,
    output logic [CNT_W-1:0] fwd_count_wb
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             valid_q,  valid_d;
    logic             two_q,    two_d;
    logic [REG_W-1:0] src1_q,   src1_d;
    logic [REG_W-1:0] src2_q,   src2_d;
    logic [CNT_W-1:0] cnt_mem_q, cnt_mem_d;
    logic [CNT_W-1:0] cnt_wb_q,  cnt_wb_d;

    logic [REG_W-1:0] op_tag [NUM_SRC];
    logic             op_use [NUM_SRC];
    logic [1:0]       op_sel [NUM_SRC];
    logic             any_mem;
    logic             any_wb;

    // Per-operand enables: operand 2 is only consulted when the instruction reads it
    always_comb begin
        op_tag[0] = src1_q;
        op_tag[1] = src2_q;
        op_use[0] = forwardingEnabled && valid_q;
        op_use[1] = forwardingEnabled && valid_q && two_q;
    end

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_sel
            fwd_select #(
                .REG_W      (REG_W),
                .EXCLUDE_PC (EXCLUDE_PC)
            ) u_fwd_select (
                .tag      (op_tag[gi]),
                .use_en   (op_use[gi]),
                .mem_dest (destination_mem),
                .mem_en   (writeBackEnabled_mem),
                .wb_dest  (destination_wb),
                .wb_en    (writeBackEnabled_wb),
                .sel      (op_sel[gi])
            );
        end
    endgenerate

    assign sel_src1 = op_sel[0];
    assign sel_src2 = op_sel[1];

    // Tag register next state: flush kills the instruction even while frozen
    always_comb begin
        valid_d = valid_q;
        two_d   = two_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        if (flush) begin
            valid_d = 1'b0;
            two_d   = 1'b0;
            src1_d  = '0;
            src2_d  = '0;
        end else if (!freeze) begin
            valid_d = valid_id;
            two_d   = twoSrc_id;
            src1_d  = src1_id;
            src2_d  = src2_id;
        end
    end

    // Counter next state: one count per unfrozen cycle, saturating, clear has priority
    always_comb begin
        any_mem   = (op_sel[0] == FWD_SEL_MEM) || (op_sel[1] == FWD_SEL_MEM);
        any_wb    = (op_sel[0] == FWD_SEL_WB)  || (op_sel[1] == FWD_SEL_WB);
        cnt_mem_d = cnt_mem_q;
        cnt_wb_d  = cnt_wb_q;
        if (clear_counters) begin
            cnt_mem_d = '0;
            cnt_wb_d  = '0;
        end else if (!freeze) begin
            if (any_mem && (cnt_mem_q != CNT_MAX)) begin
                cnt_mem_d = cnt_mem_q + 1'b1;
            end
            if (any_wb && (cnt_wb_q != CNT_MAX)) begin
                cnt_wb_d = cnt_wb_q + 1'b1;
            end
        end
    end

    // State flops; reset clears tags so no stale forwarding survives a reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            two_q     <= 1'b0;
            src1_q    <= '0;
            src2_q    <= '0;
            cnt_mem_q <= '0;
            cnt_wb_q  <= '0;
        end else begin
            valid_q   <= valid_d;
            two_q     <= two_d;
            src1_q    <= src1_d;
            src2_q    <= src2_d;
            cnt_mem_q <= cnt_mem_d;
            cnt_wb_q  <= cnt_wb_d;
        end
    end

    assign valid_exe     = valid_q;
    assign twoSrc_exe    = two_q;
    assign src1_exe      = src1_q;
    assign src2_exe      = src2_q;
    assign fwd_count_mem = cnt_mem_q;
    assign fwd_count_wb  = cnt_wb_q;

endmodule : forwarding_unit

// File: tb/tb_forwarding_unit.sv
// Bench for forwarding_unit: directed vector table, hand sequences for reset,
// freeze/flush and counter saturation, then randomized cycles against a reference model.
module tb_forwarding_unit;

    localparam int REG_W   = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_TOP = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             forwardingEnabled;
    logic             freeze;
    logic             flush;
    logic             clear_counters;
    logic             valid_id;
    logic             twoSrc_id;
    logic [REG_W-1:0] src1_id;
    logic [REG_W-1:0] src2_id;
    logic [REG_W-1:0] destination_mem;
    logic             writeBackEnabled_mem;
    logic [REG_W-1:0] destination_wb;
    logic             writeBackEnabled_wb;
    logic [1:0]       sel_src1;
    logic [1:0]       sel_src2;
    logic             valid_exe;
    logic             twoSrc_exe;
    logic [REG_W-1:0] src1_exe;
    logic [REG_W-1:0] src2_exe;
    logic [CNT_W-1:0] fwd_count_mem;
    logic [CNT_W-1:0] fwd_count_wb;

    int n_checks = 0;
    int n_fail   = 0;

    forwarding_unit #(
        .REG_W      (REG_W),
        .CNT_W      (CNT_W),
        .EXCLUDE_PC (1'b1)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .forwardingEnabled    (forwardingEnabled),
        .freeze               (freeze),
        .flush                (flush),
        .clear_counters       (clear_counters),
        .valid_id             (valid_id),
        .twoSrc_id            (twoSrc_id),
        .src1_id              (src1_id),
        .src2_id              (src2_id),
        .destination_mem      (destination_mem),
        .writeBackEnabled_mem (writeBackEnabled_mem),
        .destination_wb       (destination_wb),
        .writeBackEnabled_wb  (writeBackEnabled_wb),
        .sel_src1             (sel_src1),
        .sel_src2             (sel_src2),
        .valid_exe            (valid_exe),
        .twoSrc_exe           (twoSrc_exe),
        .src1_exe             (src1_exe),
        .src2_exe             (src2_exe),
        .fwd_count_mem        (fwd_count_mem),
        .fwd_count_wb         (fwd_count_wb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       fe;
        logic       two;
        logic [3:0] s1;
        logic [3:0] s2;
        logic [3:0] md;
        logic       me;
        logic [3:0] wd;
        logic       we;
        int         e1;
        int         e2;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference selection rule: which stage supplies an operand
    //   0 = register file, 1 = MEM, 2 = WB
    function automatic int model_sel(input logic fe, input logic used, input int tag,
                                     input int md, input logic me, input int wd, input logic we);
        if (!fe || !used) return 0;
        if (tag == 15) return 0;
        if (me && md == tag) return 1;
        if (we && wd == tag) return 2;
        return 0;
    endfunction

    function automatic int pick_tag();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 15 : r;
    endfunction

    // Model state for the random phase
    int m_valid, m_two, m_s1, m_s2, m_cmem, m_cwb;
    int e1, e2;

    initial begin
        // Table: {fe, two, s1, s2, mem dest/en, wb dest/en} -> expected sels
        vecs[0] = '{1'b1, 1'b1, 4'd3,  4'd0,  4'd3,  1'b1, 4'd3,  1'b1, 1, 0};
        vecs[1] = '{1'b1, 1'b1, 4'd3,  4'd0,  4'd3,  1'b0, 4'd3,  1'b1, 2, 0};
        vecs[2] = '{1'b1, 1'b0, 4'd1,  4'd5,  4'd5,  1'b1, 4'd1,  1'b1, 2, 0};
        vecs[3] = '{1'b1, 1'b1, 4'd15, 4'd5,  4'd15, 1'b1, 4'd5,  1'b1, 0, 2};
        vecs[4] = '{1'b0, 1'b1, 4'd6,  4'd6,  4'd6,  1'b1, 4'd6,  1'b1, 0, 0};
        vecs[5] = '{1'b1, 1'b1, 4'd8,  4'd9,  4'd9,  1'b1, 4'd8,  1'b1, 2, 1};
        vecs[6] = '{1'b1, 1'b1, 4'd2,  4'd2,  4'd2,  1'b0, 4'd2,  1'b0, 0, 0};
        vecs[7] = '{1'b1, 1'b1, 4'd15, 4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 0, 0};

        rst_n = 1'b0;
        forwardingEnabled = 1'b1;
        freeze = 1'b0;
        flush = 1'b0;
        clear_counters = 1'b0;
        valid_id = 1'b1;
        twoSrc_id = 1'b1;
        src1_id = 4'd1;
        src2_id = 4'd1;
        destination_mem = 4'd0;
        writeBackEnabled_mem = 1'b1;
        destination_wb = 4'd0;
        writeBackEnabled_wb = 1'b1;

        // Reset state: tags zero and no forwarding even though dest 0 matches tag 0
        #12;
        check("reset_valid", valid_exe, 0);
        check("reset_sel1", sel_src1, 0);
        check("reset_sel2", sel_src2, 0);
        check("reset_cmem", fwd_count_mem, 0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_counters = 1'b1;

        // Directed vectors
        for (int i = 0; i < 8; i++) begin
            tick();
            valid_id = 1'b1;
            twoSrc_id = vecs[i].two;
            src1_id = vecs[i].s1;
            src2_id = vecs[i].s2;
            writeBackEnabled_mem = 1'b0;
            writeBackEnabled_wb = 1'b0;
            tick();
            forwardingEnabled = vecs[i].fe;
            destination_mem = vecs[i].md;
            writeBackEnabled_mem = vecs[i].me;
            destination_wb = vecs[i].wd;
            writeBackEnabled_wb = vecs[i].we;
            #1;
            check($sformatf("vec%0d_src1_exe", i), src1_exe, vecs[i].s1);
            check($sformatf("vec%0d_sel1", i), sel_src1, vecs[i].e1);
            check($sformatf("vec%0d_sel2", i), sel_src2, vecs[i].e2);
            $display("vec %0d: src1=%0d src2=%0d sel1=%0d sel2=%0d", i, src1_exe, src2_exe, sel_src1, sel_src2);
        end

        // Freeze holds tags; flush beats freeze
        forwardingEnabled = 1'b1;
        tick();
        src1_id = 4'd2;
        valid_id = 1'b1;
        tick();
        freeze = 1'b1;
        src1_id = 4'd7;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("freeze_src1_hold", src1_exe, 2);
        end
        flush = 1'b1;
        destination_mem = 4'd0;
        writeBackEnabled_mem = 1'b1;
        tick();
        #1;
        check("flush_valid", valid_exe, 0);
        check("flush_src1", src1_exe, 0);
        check("flush_sel1", sel_src1, 0);
        $display("seq freeze/flush: valid_exe=%0d src1_exe=%0d", valid_exe, src1_exe);
        flush = 1'b0;
        freeze = 1'b0;

        // Disabled forwarding: full match, counters must not move
        src1_id = 4'd3;
        src2_id = 4'd3;
        twoSrc_id = 1'b1;
        destination_mem = 4'd3;
        destination_wb = 4'd3;
        writeBackEnabled_wb = 1'b1;
        forwardingEnabled = 1'b0;
        tick();
        clear_counters = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("disable_sel1", sel_src1, 0);
        check("disable_sel2", sel_src2, 0);
        check("disable_cmem", fwd_count_mem, 0);
        check("disable_cwb", fwd_count_wb, 0);
        $display("seq disable: cmem=%0d cwb=%0d", fwd_count_mem, fwd_count_wb);

        // Saturation: MEM hit on both operands for 20 cycles
        forwardingEnabled = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("sat_cmem", fwd_count_mem, CNT_TOP);
        check("sat_cwb", fwd_count_wb, 0);
        clear_counters = 1'b1;
        tick();
        check("clear_cmem", fwd_count_mem, 0);
        clear_counters = 1'b0;
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("frozen_no_count", fwd_count_mem, 0);
        freeze = 1'b0;
        tick();
        check("unfrozen_count", fwd_count_mem, 1);
        $display("seq counters: cmem=%0d", fwd_count_mem);

        // Asynchronous reset mid-run with loaded tags
        src1_id = 4'd9;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_valid", valid_exe, 0);
        check("areset_src1", src1_exe, 0);
        check("areset_cmem", fwd_count_mem, 0);
        check("areset_sel2", sel_src2, 0);
        @(negedge clk);
        rst_n = 1'b1;
        src1_id = 4'd6;
        tick();
        check("post_reset_capture", src1_exe, 6);
        $display("seq async reset: src1_exe=%0d", src1_exe);

        // Random phase: start from a known flushed, cleared state
        flush = 1'b1;
        clear_counters = 1'b1;
        tick();
        flush = 1'b0;
        clear_counters = 1'b0;
        m_valid = 0; m_two = 0; m_s1 = 0; m_s2 = 0; m_cmem = 0; m_cwb = 0;
        for (int c = 0; c < 200; c++) begin
            forwardingEnabled    = ($urandom_range(0, 7) != 0);
            freeze               = ($urandom_range(0, 4) == 0);
            flush                = ($urandom_range(0, 9) == 0);
            clear_counters       = ($urandom_range(0, 39) == 0);
            valid_id             = ($urandom_range(0, 5) != 0);
            twoSrc_id            = $urandom_range(0, 1);
            src1_id              = 4'(pick_tag());
            src2_id              = 4'(pick_tag());
            destination_mem      = 4'(pick_tag());
            writeBackEnabled_mem = $urandom_range(0, 1);
            destination_wb       = 4'(pick_tag());
            writeBackEnabled_wb  = $urandom_range(0, 1);
            #1;
            e1 = model_sel(forwardingEnabled, m_valid != 0, m_s1,
                           destination_mem, writeBackEnabled_mem, destination_wb, writeBackEnabled_wb);
            e2 = model_sel(forwardingEnabled, (m_valid != 0) && (m_two != 0), m_s2,
                           destination_mem, writeBackEnabled_mem, destination_wb, writeBackEnabled_wb);
            check("rnd_sel1", sel_src1, e1);
            check("rnd_sel2", sel_src2, e2);
            check("rnd_valid", valid_exe, m_valid);
            check("rnd_src1", src1_exe, m_s1);
            check("rnd_cmem", fwd_count_mem, m_cmem);
            check("rnd_cwb", fwd_count_wb, m_cwb);
            $display("rnd %0d: sel1=%0d sel2=%0d cmem=%0d cwb=%0d", c, sel_src1, sel_src2, fwd_count_mem, fwd_count_wb);
            // Advance the model by one clock
            if (clear_counters) begin
                m_cmem = 0;
                m_cwb = 0;
            end else if (!freeze) begin
                if ((e1 == 1 || e2 == 1) && m_cmem < CNT_TOP) m_cmem++;
                if ((e1 == 2 || e2 == 2) && m_cwb < CNT_TOP) m_cwb++;
            end
            if (flush) begin
                m_valid = 0; m_two = 0; m_s1 = 0; m_s2 = 0;
            end else if (!freeze) begin
                m_valid = valid_id;
                m_two = twoSrc_id;
                m_s1 = src1_id;
                m_s2 = src2_id;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_forwarding_unit
